// File: rtl/video_output_pkg.sv
// video_output_pkg: shared state type, constants and counter-width helper for the output-mode sequencer
package video_output_pkg;
  typedef enum logic [2:0] {RUN, WAIT_FRAME, BLANK, SWITCH, SETTLE} seq_state_t;
  localparam logic [23:0] BLACK_RGB = 24'h000000;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/video_output_mode_sequencer_hpd_debounce.sv
// hpd_debounce: synchronises and debounces the hot-plug pin, flagging each debounced rise
module hpd_debounce
  import video_output_pkg::*;
#(
  parameter int HPD_DEBOUNCE = 1024
) (
  input  logic clk_pixel,
  input  logic reset,
  input  logic hpd,
  output logic hpd_stable,
  output logic rise
);
  localparam int W = cnt_w(HPD_DEBOUNCE);
  logic [1:0] sync;
  logic [W-1:0] cnt;
  logic done;
  assign done = (sync[1] != hpd_stable) && (cnt == W'(HPD_DEBOUNCE - 1));
  assign rise = done && !hpd_stable;
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      sync <= '0;
      cnt <= '0;
      hpd_stable <= 1'b0;
    end else begin
      sync <= {sync[0], hpd};
      cnt <= (sync[1] == hpd_stable || done) ? '0 : cnt + 1'b1;
      if (done) hpd_stable <= ~hpd_stable;
    end
  end
endmodule

// File: rtl/video_output_mode_sequencer.sv
// video_output_mode_sequencer: frame-aligned mute/blank/reset/settle sequencing of DVI/HDMI mode changes and replugs
module video_output_mode_sequencer
  import video_output_pkg::*;
#(
  parameter logic DVI_DEFAULT   = 1'b0,
  parameter int   BLANK_FRAMES  = 2,
  parameter int   RESET_CYCLES  = 16,
  parameter int   SETTLE_FRAMES = 2,
  parameter int   HPD_DEBOUNCE  = 1024,
  parameter int   FRAME_TIMEOUT = 1048576
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        dvi_request,
  input  logic        hpd,
  input  logic [11:0] cx,
  input  logic [10:0] cy,
  input  logic [23:0] rgb_in,
  output logic [23:0] rgb_out,
  output logic        dvi_output,
  output logic        video_reset,
  output logic        audio_mute,
  output logic        busy,
  output logic        hpd_stable
);
  localparam int RW = cnt_w(RESET_CYCLES);
  localparam int TW = cnt_w(FRAME_TIMEOUT);
  localparam int FW = cnt_w(BLANK_FRAMES > SETTLE_FRAMES ? BLANK_FRAMES : SETTLE_FRAMES);
  seq_state_t state, state_n;
  logic [FW-1:0] fcnt, fcnt_n;
  logic [RW-1:0] rcnt;
  logic [TW-1:0] tcnt;
  logic target, replug, rise, prev_origin, frame_start;
  logic at_origin, waiting, fs_eff, enter_blank, enter_switch, blank;
  hpd_debounce #(.HPD_DEBOUNCE(HPD_DEBOUNCE)) u_hpd (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .hpd       (hpd),
    .hpd_stable(hpd_stable),
    .rise      (rise)
  );
  assign at_origin = (cx == 12'd0) && (cy == 11'd0);
  assign waiting = (state == WAIT_FRAME) || (state == BLANK) || (state == SETTLE);
  // a stalled output stage never reaches the origin, so the timeout stands in for the frame start
  assign fs_eff = frame_start || (waiting && tcnt == TW'(FRAME_TIMEOUT - 1));
  assign enter_blank = (state_n == BLANK) && (state != BLANK);
  assign enter_switch = (state_n == SWITCH) && (state != SWITCH);
  assign blank = (state == BLANK) || (state == SWITCH) || (state == SETTLE);
  assign rgb_out = blank ? BLACK_RGB : rgb_in;
  assign busy = state != RUN;
  assign audio_mute = busy || dvi_output || !hpd_stable;
  always_comb begin
    state_n = state;
    fcnt_n = fcnt;
    unique case (state)
      RUN: if (dvi_request != dvi_output || replug) state_n = WAIT_FRAME;
      WAIT_FRAME: if (fs_eff) begin
        state_n = BLANK;
        fcnt_n = '0;
      end
      BLANK: if (fs_eff) begin
        if (fcnt == FW'(BLANK_FRAMES - 1)) state_n = SWITCH;
        else fcnt_n = fcnt + 1'b1;
      end
      SWITCH: if (rcnt == RW'(RESET_CYCLES - 1)) begin
        state_n = SETTLE;
        fcnt_n = '0;
      end
      SETTLE: if (fs_eff) begin
        if (fcnt == FW'(SETTLE_FRAMES - 1)) state_n = RUN;
        else fcnt_n = fcnt + 1'b1;
      end
      default: state_n = SETTLE;
    endcase
  end
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state <= SETTLE;
      fcnt <= '0;
      rcnt <= '0;
      tcnt <= '0;
      target <= DVI_DEFAULT;
      dvi_output <= DVI_DEFAULT;
      video_reset <= 1'b0;
      replug <= 1'b0;
      prev_origin <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state <= state_n;
      fcnt <= fcnt_n;
      rcnt <= (state == SWITCH) ? rcnt + 1'b1 : '0;
      tcnt <= (state_n != state || fs_eff || !waiting) ? '0 : tcnt + 1'b1;
      if (enter_blank) target <= dvi_request;
      if (enter_switch) dvi_output <= target;
      video_reset <= state_n == SWITCH;
      replug <= rise || (replug && !enter_switch);
      prev_origin <= at_origin;
      frame_start <= at_origin && !prev_origin && !video_reset;
    end
  end
endmodule

// File: doc/video_output_mode_sequencer.md
Name: video_output_mode_sequencer

Overview:
- Controller for the dual-path DVI/HDMI TMDS output stage, running in the pixel clock domain.
- Owns the `dvi_output` select, the output-stage reset, audio mute and picture blanking.
- Applies DVI/HDMI mode changes and hot-plug re-syncs only at frame boundaries, in a fixed sequence: mute, blank, reset, settle.
- Sits between the configuration register / HPD pin and the output stage; the output stage's `cx`/`cy` feed back into it.

Parameters:
- DVI_DEFAULT, 1'b0: `dvi_output` value after reset.
- BLANK_FRAMES, 2: whole frames of black output before the switch.
- RESET_CYCLES, 16: clk_pixel cycles `video_reset` is held high.
- SETTLE_FRAMES, 2: frames kept blanked and muted after the switch.
- HPD_DEBOUNCE, 1024: cycles the synchronised HPD must stay stable before the debounced value changes.
- FRAME_TIMEOUT, 1048576: cycles without a frame start before a waiting state advances anyway.

Ports:
- clk_pixel  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- dvi_request  in  1  requested mode: 1 = DVI, 0 = HDMI. Level, not synchronised.
- hpd  in  1  raw hot-plug detect pin, asynchronous.
- cx  in  12  output-stage x coordinate.
- cy  in  11  output-stage y coordinate.
- rgb_in  in  24  pixel from the VDP.
- rgb_out  out  24  pixel sent to the output stage.
- dvi_output  out  1  mode select to the output stage.
- video_reset  out  1  reset to the output stage.
- audio_mute  out  1  forces audio samples to zero upstream.
- busy  out  1  high whenever state is not RUN.
- hpd_stable  out  1  debounced HPD level.

Behaviour:
- Reset: state=SETTLE, frame count=0, `dvi_output`=DVI_DEFAULT, `video_reset`=0, `audio_mute`=1, `busy`=1, `hpd_stable`=0, `rgb_out`=0, debounce count=0, pending-replug flag=0.
- HPD path:
  - 2-flop synchroniser on `hpd`.
  - The counter increments while the synchronised level differs from `hpd_stable` and clears when they are equal.
  - When the counter reaches HPD_DEBOUNCE-1, `hpd_stable` toggles and the counter clears.
  - A 0->1 toggle of `hpd_stable` sets `replug`. `replug` is cleared on entry to SWITCH.
- frame_start:
  - Registered compare: (cx,cy)==(0,0) while the previous cycle's (cx,cy)!=(0,0).
  - Qualified by `video_reset`==0.
  - Exactly one pulse per frame; no pulse while `video_reset` holds the counters at origin.
- Blanking: `blank`=1 in WAIT_FRAME? No — `blank`=1 in BLANK, SWITCH and SETTLE only. `rgb_out` = blank ? 24'h0 : rgb_in, a combinational mux with 0-cycle latency.
- `audio_mute`: 1 in every state except RUN. In RUN it equals `dvi_output` | ~`hpd_stable`.
- States and transitions:
  - RUN: go to WAIT_FRAME if `dvi_request`!=`dvi_output` or `replug`=1.
  - WAIT_FRAME: on frame_start go to BLANK with count=0. Picture still passes through.
  - BLANK: count frame_starts. On the BLANK_FRAMES-th go to SWITCH. On entry, `target`<=`dvi_request` is latched (latest request wins).
  - SWITCH: `dvi_output`<=`target` and `video_reset`=1 are registered on the entry cycle. Hold for exactly RESET_CYCLES cycles, then deassert and go to SETTLE with count=0.
  - SETTLE: count frame_starts. On the SETTLE_FRAMES-th go to RUN.
- Timeout: in WAIT_FRAME, BLANK and SETTLE, a cycle counter clears on each frame_start and on state entry. At FRAME_TIMEOUT-1 it is treated as a frame_start, covering a stalled or disconnected output stage.
- Request toggling:
  - A request that reverts before SWITCH still completes the sequence with `target`=current `dvi_output`. No glitch on `dvi_output`.
  - A request change during SWITCH or SETTLE is handled by RUN re-entering WAIT_FRAME on its first cycle.
- Simultaneous events: a replug and a mode change together produce one sequence.
- Reset mid-sequence: immediate return to reset values. `video_reset` drops and `dvi_output` returns to DVI_DEFAULT.
- Minimum switch latency from request: (frame_start wait) + BLANK_FRAMES frames + RESET_CYCLES + SETTLE_FRAMES frames.

Decomposition:
- Package `video_output_pkg`:
  - `seq_state_t` enum {RUN, WAIT_FRAME, BLANK, SWITCH, SETTLE}.
  - Localparam widths derived with $clog2 of RESET_CYCLES, HPD_DEBOUNCE and FRAME_TIMEOUT.
  - BLACK_RGB constant.
- One sub-module, `hpd_debounce`: synchroniser, debounce counter, `hpd_stable`, rise pulse.

Test Plan (bench frame 8x4 = 32 cycles, cx/cy driven by a counter held at 0 during `video_reset`; BLANK_FRAMES=2, RESET_CYCLES=16, SETTLE_FRAMES=2, HPD_DEBOUNCE=8, FRAME_TIMEOUT=200):
1. Reset release with hpd=1:
   - `busy`=1, `rgb_out`=0 for 2 frames, then RUN.
   - `audio_mute`=1 until `hpd_stable` rises, 10 cycles after sync (2 sync + 8 debounce).
   - Then `audio_mute`=0 with `dvi_output`=0.
   - Replug sequence follows (`hpd_stable` rose).
2. dvi_request 0->1 mid-frame:
   - `audio_mute`=1 on the next cycle.
   - `rgb_out`=0 from the next frame start.
   - `dvi_output`=1 after 64 cycles of blank; `video_reset` high for exactly 16 cycles.
   - 64 settle cycles, then `busy`=0 and `audio_mute`=1 (DVI).
3. dvi_request pulsed 0->1->0 within WAIT_FRAME:
   - Full sequence runs.
   - `dvi_output` stays 0 throughout; `video_reset` still pulses 16 cycles.
4. hpd glitch low for 5 cycles:
   - No `hpd_stable` change, no sequence.
   - A 20-cycle low then high toggles `hpd_stable` 1->0->1 and one replug sequence runs.
5. cx/cy frozen at (3,2) during BLANK:
   - State advances after 200-cycle timeouts per frame.
   - Reaches RUN without a hang.
6. Reset asserted during SWITCH:
   - Next cycle: `video_reset`=0, `dvi_output`=0, `busy`=1, state=SETTLE.
